mac_rx_fcs_check: RTL

MAC_RX_FCS_CHECK -- requirements
Module: mac_rx_fcs_check

---
 rtl/mac_pkg.sv | 33 +++
 rtl/crc32_step.sv | 20 ++
 rtl/mac_rx_fcs_check.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared CRC-32 constants, receive FSM states and byte-level helpers for the MAC RX path.
package mac_pkg;

    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } rx_state_e;

    // One entry of the reflected CRC-32 byte table; constant-folds into LUT logic.
    function automatic logic [31:0] crc32_table(input logic [7:0] idx);
        logic [31:0] c;
        c = {24'd0, idx};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [3:0] mask_bytes(input logic [7:0] mask);
        logic [3:0] n;
        n = 4'd0;
        for (int b = 0; b < 8; b++) begin
            n = n + {3'd0, mask[b]};
        end
        return n;
    endfunction

endpackage

// File: rtl/crc32_step.sv
// Combinational reflected CRC-32 update over up to eight bytes, byte 0 first, skipping masked-off bytes.
module crc32_step
    import mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [63:0] data,
    input  logic [7:0]  mask,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) begin
                crc_out = (crc_out >> 8) ^ crc32_table(crc_out[7:0] ^ data[b*8 +: 8]);
            end
        end
    end

endmodule

// File: rtl/mac_rx_fcs_check.sv
// RX FCS checker: strips the 4-byte FCS through a one-beat hold register and flags CRC and length errors at frame end.
module mac_rx_fcs_check
    import mac_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [63:0] i_data,
    input  logic [7:0]  i_valid,
    input  logic        i_last,
    output logic [63:0] o_data,
    output logic [7:0]  o_valid,
    output logic        o_last,
    output logic        o_crc_err,
    output logic        o_len_err
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);

    rx_state_e   state_reg;
    logic [63:0] hold_data_reg;
    logic [7:0]  hold_valid_reg;
    logic        flush_crc_err_reg;
    logic        flush_len_err_reg;
    logic [31:0] crc_reg;
    logic [15:0] count_reg;

    logic        accept;
    logic        frame_start;
    logic [31:0] crc_base;
    logic [31:0] crc_next;
    logic [3:0]  n_bytes;
    logic [16:0] count_sum;
    logic [15:0] count_next;
    logic        crc_err_next;
    logic        len_err_next;
    logic [7:0]  last_trim_mask;

    // Any beat arriving outside HOLD opens a new frame, including one that lands on a FLUSH cycle.
    assign accept      = |i_valid;
    assign frame_start = (state_reg != ST_HOLD);
    assign crc_base    = frame_start ? CRC32_INIT : crc_reg;

    crc32_step u_crc32_step (
        .crc_in  (crc_base),
        .data    (i_data),
        .mask    (i_valid),
        .crc_out (crc_next)
    );

    assign n_bytes        = mask_bytes(i_valid);
    assign count_sum      = {1'b0, (frame_start ? 16'd0 : count_reg)} + {13'd0, n_bytes};
    assign count_next     = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    assign crc_err_next   = (crc_next != CRC32_RESIDUE);
    assign len_err_next   = (count_next < MIN_LEN) || (count_next > MAX_LEN);
    assign last_trim_mask = hold_valid_reg >> (3'd4 - n_bytes[2:0]);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg         <= ST_IDLE;
            hold_data_reg     <= '0;
            hold_valid_reg    <= '0;
            flush_crc_err_reg <= 1'b0;
            flush_len_err_reg <= 1'b0;
            crc_reg           <= CRC32_INIT;
            count_reg         <= '0;
            o_data            <= '0;
            o_valid           <= '0;
            o_last            <= 1'b0;
            o_crc_err         <= 1'b0;
            o_len_err         <= 1'b0;
        end else begin
            o_valid   <= '0;
            o_last    <= 1'b0;
            o_crc_err <= 1'b0;
            o_len_err <= 1'b0;

            if (state_reg == ST_FLUSH) begin
                o_data    <= hold_data_reg;
                o_valid   <= hold_valid_reg;
                o_last    <= 1'b1;
                o_crc_err <= flush_crc_err_reg;
                o_len_err <= flush_len_err_reg;
                state_reg <= ST_IDLE;
            end

            if (accept) begin
                crc_reg   <= crc_next;
                count_reg <= count_next;
                if (!i_last || (n_bytes > 4'd4)) begin
                    if (state_reg == ST_HOLD) begin
                        o_data  <= hold_data_reg;
                        o_valid <= hold_valid_reg;
                    end
                    hold_data_reg     <= i_data;
                    hold_valid_reg    <= i_last ? (i_valid >> 4) : i_valid;
                    flush_crc_err_reg <= crc_err_next;
                    flush_len_err_reg <= len_err_next;
                    state_reg         <= i_last ? ST_FLUSH : ST_HOLD;
                end else if (state_reg == ST_HOLD) begin
                    o_data    <= hold_data_reg;
                    o_valid   <= last_trim_mask;
                    o_last    <= 1'b1;
                    o_crc_err <= crc_err_next;
                    o_len_err <= len_err_next;
                    state_reg <= ST_IDLE;
                end else if (state_reg == ST_FLUSH) begin
                    // A tiny frame ending while the output is busy flushing: emit its empty end beat next cycle.
                    hold_data_reg     <= '0;
                    hold_valid_reg    <= '0;
                    flush_crc_err_reg <= crc_err_next;
                    flush_len_err_reg <= 1'b1;
                    state_reg         <= ST_FLUSH;
                end else begin
                    o_data    <= '0;
                    o_valid   <= '0;
                    o_last    <= 1'b1;
                    o_crc_err <= crc_err_next;
                    o_len_err <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            end
        end
    end

endmodule
